// File: rtl/fft_ctrl_pkg.sv
// Shared constants, FSM encoding and helpers for the FFT frame sequencer.
package fft_ctrl_pkg;

  localparam int LOG2N_DFLT = 12;
  localparam int DW_DFLT    = 16;
  localparam int SW_DFLT    = 12;

  localparam logic [SW_DFLT-1:0] SCALE_DFLT = 12'hAAA;
  localparam int                 NPTS       = 1 << LOG2N_DFLT;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_START,
    ST_LOAD,
    ST_UNLOAD
  } state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/fft_ctrl_cfg_shadow.sv
// Shadow copy of the core's direction/scale configuration; the write strobes
// reach the core only while the sequencer sits in its APPLY cycle.
module fft_ctrl_cfg_shadow
  import fft_ctrl_pkg::*;
#(
  parameter int            SW         = SW_DFLT,
  parameter logic [SW-1:0] SCALE_INIT = fft_ctrl_pkg::SCALE_DFLT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic          cfg_fwd_inv,
  input  logic [SW-1:0] cfg_scale,
  input  logic          apply,
  output logic          cfg_pending,
  output logic          core_fwd_inv,
  output logic          core_fwd_inv_we,
  output logic [SW-1:0] core_scale_sch,
  output logic          core_scale_sch_we
);

  logic          fwd_q;
  logic [SW-1:0] scale_q;

  // Pending comes out of reset set, so the defaults reach the core before
  // the first frame. A write landing on the APPLY cycle wins: it is kept
  // and stays pending for the next frame boundary.
  // NOTE: registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_q       <= 1'b1;
      scale_q     <= SCALE_INIT;
      cfg_pending <= 1'b1;
    end else if (cfg_we) begin
      fwd_q       <= cfg_fwd_inv;
      scale_q     <= cfg_scale;
      cfg_pending <= 1'b1;
    end else if (apply) begin
      cfg_pending <= 1'b0;
    end
  end

  assign core_fwd_inv_we   = apply;
  assign core_scale_sch_we = apply;
  assign core_fwd_inv      = apply & fwd_q;
  assign core_scale_sch    = apply ? scale_q : '0;

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for a burst-mode FFT core: applies config at frame edges,
// streams one frame in and forwards the spectrum. Define FFT_CTRL_STATS_EN
// to add saturating frame/underrun counters.
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int            LOG2N      = LOG2N_DFLT,
  parameter int            DW         = DW_DFLT,
  parameter int            SW         = SW_DFLT,
  parameter logic [SW-1:0] SCALE_DFLT = fft_ctrl_pkg::SCALE_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic             cfg_fwd_inv,
  input  logic [SW-1:0]    cfg_scale,
  output logic             cfg_pending,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_re,
  input  logic [DW-1:0]    in_im,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DW-1:0]    out_re,
  output logic [DW-1:0]    out_im,
  output logic [LOG2N-1:0] out_index,
  output logic             out_sop,
  output logic             out_eop,
  output logic             frame_done,
  output logic             err_underrun,
  output logic             err_index,
  input  logic             err_clr,
`ifdef FFT_CTRL_STATS_EN
  output logic [31:0]      frame_cnt,
  output logic [31:0]      underrun_cnt,
`endif
  output logic             core_fwd_inv,
  output logic             core_fwd_inv_we,
  output logic             core_start,
  output logic [SW-1:0]    core_scale_sch,
  output logic             core_scale_sch_we,
  input  logic             core_rfd,
  input  logic             core_busy,
  input  logic             core_done,
  input  logic             core_edone,
  input  logic             core_dv,
  output logic [DW-1:0]    core_xn_re,
  output logic [DW-1:0]    core_xn_im,
  input  logic [LOG2N-1:0] core_xn_index,
  input  logic [DW-1:0]    core_xk_re,
  input  logic [DW-1:0]    core_xk_im,
  input  logic [LOG2N-1:0] core_xk_index
);

  localparam logic [LOG2N:0] CNT_ONE = (LOG2N+1)'(1);

  state_t           state_q, state_d;
  logic [LOG2N:0]   cnt_q;
  logic [LOG2N-1:0] cnt_dly_q;
  logic             slot_dly_q;
  logic             rfd_q;
  logic             slot;
  logic             unload_dv;
  logic             unused_edone;

  // The core finishes its own frame bookkeeping; edone carries nothing we need.
  assign unused_edone = core_edone;

  // A sample slot is every rfd cycle of the frame, valid or not: the core
  // cannot stall, so a missing sample becomes a zero plus an underrun flag.
  assign slot      = (state_q == ST_LOAD) && core_rfd && !cnt_q[LOG2N];
  assign in_ready  = slot;
  assign unload_dv = (state_q == ST_UNLOAD) && core_dv;

  fft_ctrl_cfg_shadow #(
    .SW         (SW),
    .SCALE_INIT (SCALE_DFLT)
  ) u_cfg_shadow (
    .clk               (clk),
    .rst_n             (rst_n),
    .cfg_we            (cfg_we),
    .cfg_fwd_inv       (cfg_fwd_inv),
    .cfg_scale         (cfg_scale),
    .apply             (state_q == ST_APPLY),
    .cfg_pending       (cfg_pending),
    .core_fwd_inv      (core_fwd_inv),
    .core_fwd_inv_we   (core_fwd_inv_we),
    .core_scale_sch    (core_scale_sch),
    .core_scale_sch_we (core_scale_sch_we)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output is given a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    core_start = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!core_busy) begin
          if (cfg_pending)   state_d = ST_APPLY;
          else if (in_valid) state_d = ST_START;
        end
      end
      ST_APPLY: state_d = ST_IDLE;
      ST_START: begin
        core_start = 1'b1;
        state_d    = ST_LOAD;
      end
      ST_LOAD: begin
        if (cnt_q[LOG2N] || (rfd_q && !core_rfd)) state_d = ST_UNLOAD;
      end
      ST_UNLOAD: begin
        if (core_done || out_eop) begin
          frame_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Input side: one register stage towards the core, so the core's
  // xn_index in the next cycle must equal the slot number just consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      cnt_dly_q  <= '0;
      slot_dly_q <= 1'b0;
      rfd_q      <= 1'b0;
      core_xn_re <= '0;
      core_xn_im <= '0;
    end else begin
      rfd_q      <= (state_q == ST_LOAD) && core_rfd;
      slot_dly_q <= slot;
      cnt_dly_q  <= cnt_q[LOG2N-1:0];
      if (state_q == ST_START) cnt_q <= '0;
      else if (slot)           cnt_q <= cnt_q + CNT_ONE;
      if (slot) begin
        core_xn_re <= in_valid ? in_re : '0;
        core_xn_im <= in_valid ? in_im : '0;
      end
    end
  end

  // Output side: spectrum registered once, markers decoded from xk_index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_index <= '0;
    end else begin
      out_valid <= unload_dv;
      out_sop   <= unload_dv && (core_xk_index == '0);
      out_eop   <= unload_dv && (&core_xk_index);
      if (unload_dv) begin
        out_re    <= core_xk_re;
        out_im    <= core_xk_im;
        out_index <= core_xk_index;
      end
    end
  end

  // Sticky faults; a set in the same cycle as err_clr keeps the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_underrun <= 1'b0;
      err_index    <= 1'b0;
    end else begin
      if (slot && !in_valid) err_underrun <= 1'b1;
      else if (err_clr)      err_underrun <= 1'b0;
      if (slot_dly_q && (core_xn_index != cnt_dly_q)) err_index <= 1'b1;
      else if (err_clr)                               err_index <= 1'b0;
    end
  end

`ifdef FFT_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt    <= '0;
      underrun_cnt <= '0;
    end else begin
      frame_cnt    <= sat_inc32(err_clr ? 32'd0 : frame_cnt, frame_done);
      underrun_cnt <= sat_inc32(err_clr ? 32'd0 : underrun_cnt, slot && !in_valid);
    end
  end
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with a cycle-level model of the FFT core.
`timescale 1ns/1ps
module tb_fft_frame_ctrl;

  localparam int LOG2N = 12;
  localparam int DW    = 16;
  localparam int SW    = 12;
  localparam int N     = 1 << LOG2N;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_we = 1'b0, cfg_fwd_inv = 1'b0;
  logic [SW-1:0]    cfg_scale = '0;
  logic             cfg_pending;
  logic             in_valid = 1'b0;
  logic [DW-1:0]    in_re = '0, in_im = '0;
  logic             in_ready, out_valid, out_sop, out_eop, frame_done;
  logic [DW-1:0]    out_re, out_im;
  logic [LOG2N-1:0] out_index;
  logic             err_underrun, err_index;
  logic             err_clr = 1'b0;
`ifdef FFT_CTRL_STATS_EN
  logic [31:0]      frame_cnt, underrun_cnt;
`endif
  logic             core_fwd_inv, core_fwd_inv_we, core_start, core_scale_sch_we;
  logic [SW-1:0]    core_scale_sch;
  logic             core_rfd = 1'b0, core_busy = 1'b0, core_done = 1'b0;
  logic             core_edone = 1'b0, core_dv = 1'b0;
  logic [DW-1:0]    core_xn_re, core_xn_im;
  logic [LOG2N-1:0] core_xn_index = '0;
  logic [DW-1:0]    core_xk_re = '0, core_xk_im = '0;
  logic [LOG2N-1:0] core_xk_index = '0;

  fft_frame_ctrl #(.LOG2N(LOG2N), .DW(DW), .SW(SW), .SCALE_DFLT(12'hAAA)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_fwd_inv(cfg_fwd_inv), .cfg_scale(cfg_scale), .cfg_pending(cfg_pending),
    .in_valid(in_valid), .in_re(in_re), .in_im(in_im), .in_ready(in_ready),
    .out_valid(out_valid), .out_re(out_re), .out_im(out_im), .out_index(out_index),
    .out_sop(out_sop), .out_eop(out_eop), .frame_done(frame_done),
    .err_underrun(err_underrun), .err_index(err_index), .err_clr(err_clr),
`ifdef FFT_CTRL_STATS_EN
    .frame_cnt(frame_cnt), .underrun_cnt(underrun_cnt),
`endif
    .core_fwd_inv(core_fwd_inv), .core_fwd_inv_we(core_fwd_inv_we), .core_start(core_start),
    .core_scale_sch(core_scale_sch), .core_scale_sch_we(core_scale_sch_we),
    .core_rfd(core_rfd), .core_busy(core_busy), .core_done(core_done),
    .core_edone(core_edone), .core_dv(core_dv),
    .core_xn_re(core_xn_re), .core_xn_im(core_xn_im), .core_xn_index(core_xn_index),
    .core_xk_re(core_xk_re), .core_xk_im(core_xk_im), .core_xk_index(core_xk_index)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Core model and per-frame observations
  int            slot, hs, xn_err, out_err, n_sop, n_eop, n_done, n_start, n_apply;
  int            out_exp_idx, apply_at_start, err_idx_k, cph, u, wait_cnt;
  int            drop_at = -1, skip_at = -1, cfg_at = -1;
  logic          want_frame = 1'b0;
  logic          prev_slot = 1'b0;
  int            prev_k;
  logic          err_idx_seen;
  logic          apply_fwd;
  logic [SW-1:0] apply_scale;

  function automatic logic [DW-1:0] exp_xn(input int k);
    if (drop_at >= 0 && k >= drop_at && k < drop_at + 3) return '0;
    return DW'(k);
  endfunction

  function automatic logic [DW-1:0] xk_re_of(input int idx);
    return DW'(idx + 1000);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    // registered outputs produced by the edge just passed
    if (prev_slot && (core_xn_re !== exp_xn(prev_k) || core_xn_im !== '0)) xn_err++;
    if (out_valid) begin
      if (out_index !== LOG2N'(out_exp_idx) || out_re !== xk_re_of(out_exp_idx) ||
          out_im !== ~DW'(out_exp_idx)) out_err++;
      if (out_sop) n_sop++;
      if (out_eop) n_eop++;
      out_exp_idx++;
    end
    if (err_index && !err_idx_seen) begin
      err_idx_seen = 1'b1;
      err_idx_k    = slot - 1;
    end
    // drive the core model and the sample stream for the coming edge
    case (cph)
      1: begin
        if (slot >= N) begin core_rfd = 1'b0; cph = 2; wait_cnt = 2; end
        else core_rfd = 1'b1;
      end
      2: begin
        if (wait_cnt > 0) wait_cnt--;
        else if (u < N) begin
          core_dv = 1'b1; core_xk_index = LOG2N'(u);
          core_xk_re = xk_re_of(u); core_xk_im = ~DW'(u); u++;
        end else begin
          core_dv = 1'b0; cph = 0;
        end
      end
      default: begin core_rfd = 1'b0; core_dv = 1'b0; end
    endcase
    core_xn_index = (skip_at >= 0 && slot - 1 == skip_at) ? LOG2N'(slot) : LOG2N'(slot - 1);
    in_valid    = want_frame && !(cph == 1 && drop_at >= 0 && slot >= drop_at && slot < drop_at + 3);
    in_re       = DW'(slot);
    in_im       = '0;
    cfg_we      = (cfg_at >= 0 && cph == 1 && slot == cfg_at);
    cfg_fwd_inv = 1'b0;
    cfg_scale   = 12'h555;
    #1;
    // combinational outputs that act at the coming edge
    prev_slot = in_ready;
    prev_k    = slot;
    if (in_ready) begin
      slot++;
      if (in_valid) hs++;
    end
    if (core_fwd_inv_we) begin
      n_apply++; apply_fwd = core_fwd_inv; apply_scale = core_scale_sch;
    end
    if (core_start) begin
      n_start++; apply_at_start = n_apply; cph = 1;
      slot = 0; hs = 0; xn_err = 0; out_err = 0; n_sop = 0; n_eop = 0;
      out_exp_idx = 0; u = 0; err_idx_seen = 1'b0; err_idx_k = -1;
    end
    if (frame_done) n_done++;
  endtask

  task automatic run_until_done(input int target, input string tag);
    int i;
    i = 0;
    while (n_done < target && i < 3 * N) begin step(); i++; end
    check({tag, "_done"}, n_done, target);
  endtask

  task automatic check_frame(input string tag, input int exp_hs);
    check({tag, "_handshakes"}, hs, exp_hs);
    check({tag, "_xn_data_errs"}, xn_err, 0);
    check({tag, "_out_count"}, out_exp_idx, N);
    check({tag, "_out_data_errs"}, out_err, 0);
    check({tag, "_sop"}, n_sop, 1);
    check({tag, "_eop"}, n_eop, 1);
  endtask

  initial begin
    n_done = 0; n_start = 0; n_apply = 0; cph = 0; slot = 0; hs = 0;
    xn_err = 0; out_err = 0; n_sop = 0; n_eop = 0; out_exp_idx = 0; u = 0;
    err_idx_seen = 1'b0; err_idx_k = -1; apply_fwd = 1'b0; apply_scale = '0;
    #23;
    check("rst_cfg_pending", cfg_pending, 1);
    check("rst_ctrl_outs", {in_ready, out_valid, out_sop, out_eop, frame_done, err_underrun,
                            err_index, core_start, core_fwd_inv, core_fwd_inv_we, core_scale_sch_we}, 0);
    check("rst_scale_sch", core_scale_sch, 0);
    check("rst_xn", {core_xn_re, core_xn_im}, 0);

    // Default configuration applied once after reset, no frame started
    rst_n = 1'b1;
    repeat (6) step();
    check("dflt_apply_cnt", n_apply, 1);
    check("dflt_fwd", apply_fwd, 1);
    check("dflt_scale", apply_scale, 12'hAAA);
    check("dflt_pending", cfg_pending, 0);
    check("dflt_no_start", n_start, 0);

    // Frame 1: clean ramp, config written mid-load
    cfg_at = 500; want_frame = 1'b1;
    run_until_done(1, "f1");
    check_frame("f1", N);
    check("f1_no_strobe_in_frame", n_apply, 1);
    check("f1_pending_held", cfg_pending, 1);
    check("f1_err_underrun", err_underrun, 0);
    check("f1_err_index", err_index, 0);

    // Frame 2: new config applied first, 3-sample underrun, one bad index
    cfg_at = -1; drop_at = 100; skip_at = 300;
    run_until_done(2, "f2");
    check("f2_apply_before_start", apply_at_start, 2);
    check("f2_fwd", apply_fwd, 0);
    check("f2_scale", apply_scale, 12'h555);
    check_frame("f2", N - 3);
    check("f2_err_underrun", err_underrun, 1);
    check("f2_err_index", err_index, 1);
    check("f2_err_index_cycle", err_idx_k, skip_at + 1);

    want_frame = 1'b0;
    step(); step();
    check("idle_errs_sticky", {err_underrun, err_index}, 2'b11);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    step();
    check("clr_err_underrun", err_underrun, 0);
    check("clr_err_index", err_index, 0);
    drop_at = -1; skip_at = -1;

    // Frame 3: reset asserted at sample 2000
    want_frame = 1'b1;
    for (int i = 0; i < 3 * N && !(cph == 1 && slot >= 2000); i++) step();
    check("f3_reached_2000", slot, 2000);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pending", cfg_pending, 1);
    check("mid_rst_ctrl_outs", {in_ready, out_valid, out_sop, out_eop, frame_done, err_underrun,
                                err_index, core_start, core_fwd_inv, core_fwd_inv_we, core_scale_sch_we}, 0);
    check("mid_rst_xn", {core_xn_re, core_xn_im}, 0);
    check("mid_rst_out", {out_re, out_im, 4'b0, out_index}, 0);
    cph = 0; core_rfd = 1'b0; core_dv = 1'b0; prev_slot = 1'b0;
    n_apply = 0; n_start = 0; n_done = 0; slot = 0;
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 50 && n_start == 0; i++) step();
    check("rst_restart", n_start, 1);
    check("rst_apply_before_start", apply_at_start, 1);
    check("rst_fwd", apply_fwd, 1);
    check("rst_scale", apply_scale, 12'hAAA);
    run_until_done(1, "f3");
    check_frame("f3", N);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
- Sequencer wrapped around the 4096-point burst-mode FFT core (xfft_v7_1 port set).
- Applies direction and scaling configuration only at frame boundaries.
- Issues start, streams one frame of input samples into the core and forwards the unloaded spectrum with frame markers.
- Reports underrun and index-misalignment faults; sits between the worker's sample stream and the core.

Parameters:
- LOG2N, 12, log2 of transform length; index width.
- DW, 16, sample component width.
- SW, 12, scale schedule width.
- SCALE_DFLT, 12'hAAA, scale schedule applied after reset.

Ports:
- clk in 1: the only clock.
- rst_n in 1: asynchronous, active-low reset.
- cfg_we in 1: config write strobe.
- cfg_fwd_inv in 1: 1 = forward transform.
- cfg_scale in SW: scale schedule.
- cfg_pending out 1: config latched but not yet applied.
- in_valid in 1; in_re, in_im in DW; in_ready out 1.
- out_valid out 1; out_re, out_im out DW; out_index out LOG2N; out_sop out 1; out_eop out 1.
- frame_done out 1: one-cycle pulse when a frame completes.
- err_underrun out 1: sticky. err_index out 1: sticky. err_clr in 1: clears both.
- core_fwd_inv, core_fwd_inv_we, core_start out 1; core_scale_sch out SW; core_scale_sch_we out 1.
- core_rfd, core_busy, core_done, core_edone, core_dv in 1.
- core_xn_re, core_xn_im out DW; core_xn_index in LOG2N.
- core_xk_re, core_xk_im in DW; core_xk_index in LOG2N.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; all outputs 0 except cfg_pending=1.
  - Shadow config = {fwd=1, SCALE_DFLT}, so defaults are written before the first frame.
- Shadow config:
  - cfg_we loads the shadow in any state and sets cfg_pending.
  - cfg_we in the same cycle as APPLY: the new value is kept and cfg_pending stays 1.
- FSM states IDLE, APPLY, START, LOAD, UNLOAD.
- IDLE:
  - If cfg_pending and !core_busy, go to APPLY.
  - Else if in_valid and !core_busy, go to START.
- APPLY:
  - One cycle: core_fwd_inv_we=core_scale_sch_we=1 with shadow values; clear cfg_pending.
  - Go to IDLE.
- START:
  - core_start=1 for one cycle; go to LOAD.
- LOAD:
  - in_ready = core_rfd && (cnt < 2^LOG2N).
  - core_xn_re/im are registered from in_re/im with 1-cycle latency; cnt (LOG2N+1 bits) advances every rfd cycle.
  - rfd cycle with !in_valid: drive zero into the core, set err_underrun; the frame continues (the core cannot stall).
  - Each rfd cycle: core_xn_index ≠ cnt delayed by one cycle sets err_index.
  - rfd falling, or cnt reaching 2^LOG2N: go to UNLOAD.
- UNLOAD:
  - out_* = core_xk_* registered one cycle, qualified by core_dv.
  - out_sop when xk_index==0; out_eop when xk_index==2^LOG2N-1.
  - No backpressure.
  - core_done, or eop emitted: frame_done pulse, then go to IDLE.
- core_edone is ignored.
- err_clr has priority below a same-cycle error set (the error stays set).
- Reset mid-frame: everything is abandoned. The core is not reset by this block, so a partial core frame must be flushed by the core's own reset.

Optional Feature:
- FFT_CTRL_STATS_EN defined: adds 32-bit outputs frame_cnt and underrun_cnt, saturating.
  - Incremented on frame_done and on each underrun cycle.
  - Cleared by reset and err_clr.
- Not defined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fft_ctrl_pkg holds:
  - FSM state enum.
  - Defaults for LOG2N, DW, SW.
  - SCALE_DFLT.
  - Frame-length constant NPTS = 1<<LOG2N.
- One sub-module is natural: fft_ctrl_cfg_shadow (shadow registers plus pending flag plus APPLY strobe generation).
- FSM and datapath stay in the top module.

Test Plan:
- Release reset, keep in_valid=0 → one APPLY cycle with fwd_inv=1, scale_sch=12'hAAA; cfg_pending drops to 0.
- Write cfg fwd=0, scale=12'h555 while in LOAD → no write strobes until UNLOAD ends; APPLY follows, then the next frame starts.
- Continuous 4096-sample ramp (re=k, im=0) → exactly 4096 in_ready handshakes; core_xn_re at rfd cycle j equals j; one out_sop, one out_eop, one frame_done.
- Drop in_valid for 3 cycles at sample 100 → core receives zeros at 100–102; err_underrun=1; frame still completes; err_clr clears it.
- Model core_xn_index skipping one value → err_index=1 on the following cycle.
- Assert rst_n low at sample 2000 → all outputs 0 asynchronously; after release, default config is re-applied before a new START.
